// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter feeding four coalescing channel buffers into a single slow-domain req/ack handshake.
// Grant lands two cycles after ch_req; ack is seen three cycles after it rises; a timeout or an ack is followed by a fixed low gap.
module cdc_xfer_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 64
) (
  input  logic         clk_fast,
  input  logic         reset_n,
  input  logic [3:0]   ch_req,
  input  logic [127:0] ch_data,
  output logic [3:0]   ch_done,
  output logic [3:0]   ch_pending,
  output logic         xfer_req,
  output logic [31:0]  xfer_data,
  input  logic         xfer_ack_async,
  output logic         timeout_err,
  output logic [1:0]   err_ch
);

  localparam int MAXC = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   buffer [4];
  logic [3:0]    pending;
  logic          sync1, sync2, sync3;
  logic          ack_rise;
  logic [1:0]    rr_ptr, rr_idx, grant_ch, cur_ch;
  logic          grant_vld;
  logic          do_grant, do_ack, do_tout;

  assign ch_pending = pending;

  // sync1/sync2 resolve metastability; sync3 turns the level into a single-cycle rise.
  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= xfer_ack_async;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign ack_rise = sync2 & ~sync3;

  // Scan from the highest offset down so the nearest pending channel after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = rr_ptr;
    rr_idx    = rr_ptr;
    for (int j = 3; j >= 0; j--) begin
      rr_idx = rr_ptr + 2'(j);
      if (pending[rr_idx]) begin
        grant_vld = 1'b1;
        grant_ch  = rr_idx;
      end
    end
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = REQ;
      REQ:     if (ack_rise || cnt == TO_LAST) state_nxt = GAP;
      GAP:     if (cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_grant = 1'b0;
    do_ack   = 1'b0;
    do_tout  = 1'b0;
    case (state)
      IDLE: do_grant = grant_vld;
      REQ: begin
        do_ack  = ack_rise;
        do_tout = !ack_rise && (cnt == TO_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) buffer[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (ch_req[i]) buffer[i] <= ch_data[32*i +: 32];
    end
  end

  // A new ch_req always re-arms pending, even for the channel being granted this edge.
  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      cur_ch      <= '0;
      rr_ptr      <= '0;
      ch_done     <= '0;
      timeout_err <= 1'b0;
      err_ch      <= '0;
    end else begin
      pending     <= (pending & ~(do_grant ? (4'b0001 << grant_ch) : 4'b0000)) | ch_req;
      ch_done     <= do_ack ? (4'b0001 << cur_ch) : 4'b0000;
      timeout_err <= do_tout;
      if (do_tout) err_ch <= cur_ch;
      if (do_grant) begin
        xfer_req  <= 1'b1;
        xfer_data <= buffer[grant_ch];
        cur_ch    <= grant_ch;
        rr_ptr    <= grant_ch + 2'd1;
      end else if (do_ack || do_tout) begin
        xfer_req  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter: a timestamp-based model is compared every cycle,
// and the directed sequences pin literal values at known cycles.
module tb_cdc_xfer_arbiter;

  localparam int TO = 1024;
  localparam int GP = 64;

  logic         clk_fast = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   ch_req = '0;
  logic [127:0] ch_data = '0;
  logic         xfer_ack_async = 1'b0;
  logic [3:0]   ch_done, ch_pending;
  logic         xfer_req, timeout_err;
  logic [31:0]  xfer_data;
  logic [1:0]   err_ch;

  always #5 clk_fast = ~clk_fast;

  cdc_xfer_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
    .clk_fast(clk_fast), .reset_n(reset_n), .ch_req(ch_req), .ch_data(ch_data),
    .ch_done(ch_done), .ch_pending(ch_pending), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_ack_async(xfer_ack_async), .timeout_err(timeout_err), .err_ch(err_ch)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 requesting, 2 gap; durations measured from entry timestamps.
  logic [3:0]  m_pend;
  logic [31:0] m_buf [4];
  logic        m_req, m_terr, m_rise;
  logic [31:0] m_data;
  logic [3:0]  m_done;
  logic [1:0]  m_errch;
  logic        a1, a2, a3;
  int          phase, gch, nrr, g_sel;
  bit          found;
  longint      cyc, t_start;

  always @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_req = 0; m_data = '0; m_done = '0; m_terr = 0; m_errch = '0;
      for (int i = 0; i < 4; i++) m_buf[i] = '0;
      a1 = 0; a2 = 0; a3 = 0; phase = 0; gch = 0; nrr = 0; cyc = 0; t_start = 0;
    end else begin
      m_rise = a2 & ~a3;   // ack sampled two edges ago is new
      m_done = '0;
      m_terr = 0;
      if (phase == 0) begin
        if (m_pend != 0) begin
          found = 0;
          g_sel = 0;
          for (int k = 0; k < 4; k++)
            if (!found && m_pend[(nrr + k) % 4]) begin
              g_sel = (nrr + k) % 4;
              found = 1;
            end
          m_data = m_buf[g_sel];
          m_pend[g_sel] = 0;
          m_req = 1; phase = 1; t_start = cyc + 1; gch = g_sel; nrr = (g_sel + 1) % 4;
        end
      end else if (phase == 1) begin
        if (m_rise) begin
          m_req = 0; m_done[gch] = 1; phase = 2; t_start = cyc + 1;
        end else if (cyc - t_start + 1 == TO) begin
          m_req = 0; m_terr = 1; m_errch = 2'(gch); phase = 2; t_start = cyc + 1;
        end
      end else begin
        if (cyc - t_start + 1 == GP) phase = 0;
      end
      for (int i = 0; i < 4; i++)
        if (ch_req[i]) begin
          m_pend[i] = 1;
          m_buf[i] = ch_data[32*i +: 32];
        end
      a3 = a2; a2 = a1; a1 = xfer_ack_async;
      cyc++;
    end
  end

  always @(posedge clk_fast) begin
    #2;
    check("cmp_pending", 32'(ch_pending), 32'(m_pend));
    check("cmp_done", 32'(ch_done), 32'(m_done));
    check("cmp_req", 32'(xfer_req), 32'(m_req));
    check("cmp_data", xfer_data, m_data);
    check("cmp_terr", 32'(timeout_err), 32'(m_terr));
    check("cmp_errch", 32'(err_ch), 32'(m_errch));
  end

  int done_cnt [4];
  int terr_cnt = 0;
  int low_run = 0;
  int last_low_run = 0;

  initial for (int i = 0; i < 4; i++) done_cnt[i] = 0;

  always @(negedge clk_fast) begin
    for (int i = 0; i < 4; i++) if (ch_done[i] === 1'b1) done_cnt[i]++;
    if (timeout_err === 1'b1) terr_cnt++;
    if (xfer_req === 1'b0) low_run++;
    else begin
      if (low_run > 0) last_low_run = low_run;
      low_run = 0;
    end
  end

  task automatic send(input logic [3:0] req, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3);
    ch_req = req;
    ch_data = {d3, d2, d1, d0};
    @(negedge clk_fast);
    ch_req = '0;
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string name);
    int n = 0;
    while (xfer_req !== lvl && n < budget) begin
      @(negedge clk_fast);
      n++;
    end
    check(name, 32'(xfer_req), 32'(lvl));
  endtask

  // One slow-clock-wide ack: three fast cycles.
  task automatic ack_pulse();
    xfer_ack_async = 1'b1;
    repeat (3) @(negedge clk_fast);
    xfer_ack_async = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  int d_before, t_before;

  initial begin
    repeat (3) @(negedge clk_fast);
    reset_n = 1'b1;
    @(negedge clk_fast);
    check("rst_req", 32'(xfer_req), 0);
    check("rst_pending", 32'(ch_pending), 0);
    check("rst_data", xfer_data, 0);
    check("rst_errch", 32'(err_ch), 0);

    // Round robin: two bursts, each served 0..3.
    for (int b = 0; b < 2; b++) begin
      send(4'b1111, 4*b + 1, 4*b + 2, 4*b + 3, 4*b + 4);
      check("rr_pending", 32'(ch_pending), 32'hF);
      for (int k = 0; k < 4; k++) begin
        wait_req(1'b1, 100, "rr_req_up");
        check("rr_data", xfer_data, 32'(4*b + k + 1));
        ack_pulse();
        check("rr_done", 32'(ch_done), 32'(1 << k));
      end
    end
    repeat (GP + 2) @(negedge clk_fast);

    // Single transfer with exact latency.
    send(4'b0001, 32'hDEADBEEF, 0, 0, 0);
    check("single_pending_c1", 32'(ch_pending), 32'h1);
    check("single_req_c1", 32'(xfer_req), 0);
    @(negedge clk_fast);
    check("single_req_c2", 32'(xfer_req), 1);
    check("single_data_c2", xfer_data, 32'hDEADBEEF);
    ack_pulse();
    check("single_done", 32'(ch_done), 32'h1);
    check("single_req_drop", 32'(xfer_req), 0);

    // Request during the gap; low time must be at least the gap length.
    send(4'b1000, 0, 0, 0, 32'h33);
    wait_req(1'b1, 120, "gap_req_up");
    check("gap_data", xfer_data, 32'h33);
    @(negedge clk_fast);
    check("gap_len_min", 32'(last_low_run >= GP), 1);
    ack_pulse();
    check("gap_done", 32'(ch_done), 32'h8);
    repeat (GP + 2) @(negedge clk_fast);

    // Coalesce: ch2 rewritten while ch0 is in flight.
    d_before = done_cnt[2];
    send(4'b0101, 32'hC0DE, 0, 32'hA, 0);
    wait_req(1'b1, 10, "coal_req0");
    check("coal_data0", xfer_data, 32'hC0DE);
    send(4'b0100, 0, 0, 32'hB, 0);
    check("coal_data0_stable", xfer_data, 32'hC0DE);
    ack_pulse();
    check("coal_done0", 32'(ch_done), 32'h1);
    wait_req(1'b1, 120, "coal_req2");
    check("coal_data2", xfer_data, 32'hB);
    ack_pulse();
    check("coal_done2", 32'(ch_done), 32'h4);
    repeat (GP + 20) @(negedge clk_fast);
    check("coal_once", 32'(done_cnt[2] - d_before), 1);
    check("coal_idle_req", 32'(xfer_req), 0);
    check("coal_idle_pending", 32'(ch_pending), 0);

    // Timeout on ch3, never acked.
    d_before = done_cnt[3];
    send(4'b1000, 0, 0, 0, 32'h3333);
    wait_req(1'b1, 10, "to_req_up");
    begin
      int n = 0;
      while (xfer_req === 1'b1 && n < TO + 50) begin
        @(negedge clk_fast);
        n++;
      end
      check("to_high_len", 32'(n), 32'(TO));
    end
    check("to_err_pulse", 32'(timeout_err), 1);
    check("to_err_ch", 32'(err_ch), 3);
    check("to_no_done", 32'(ch_done), 0);

    // Late ack inside the gap is ignored.
    ack_pulse();
    repeat (10) @(negedge clk_fast);
    check("late_no_done", 32'(done_cnt[3] - d_before), 0);
    check("late_req", 32'(xfer_req), 0);
    check("late_errch_hold", 32'(err_ch), 3);

    // Reset while requesting on ch1.
    send(4'b0010, 0, 32'h1111, 0, 0);
    wait_req(1'b1, 120, "rst_mid_req_up");
    check("rst_mid_data", xfer_data, 32'h1111);
    d_before = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
    t_before = terr_cnt;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_fast);
      check("rst_mid_req", 32'(xfer_req), 0);
      check("rst_mid_pending", 32'(ch_pending), 0);
      check("rst_mid_dataz", xfer_data, 0);
      check("rst_mid_errch", 32'(err_ch), 0);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk_fast);
    check("rst_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - d_before), 0);
    check("rst_no_terr", 32'(terr_cnt - t_before), 0);

    // Pointer back at channel 0 after reset.
    send(4'b1001, 32'hC0, 0, 0, 32'hC3);
    @(negedge clk_fast);
    check("post_rst_req_c2", 32'(xfer_req), 1);
    check("post_rst_data0", xfer_data, 32'hC0);
    ack_pulse();
    check("post_rst_done0", 32'(ch_done), 32'h1);
    wait_req(1'b1, 120, "post_rst_req3");
    check("post_rst_data3", xfer_data, 32'hC3);
    ack_pulse();
    check("post_rst_done3", 32'(ch_done), 32'h8);
    repeat (GP + 5) @(negedge clk_fast);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_xfer_arbiter.md
CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: clk_fast cycles xfer_req may stay high awaiting ack.
REQ-002 SHALL have parameter GAP_CYCLES, default 64: minimum clk_fast cycles xfer_req stays low between transfers.
REQ-003 clk_fast  input  1  source clock (100 MHz); all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ch_req  input  4  per-channel 1-cycle transfer request pulses.
REQ-006 ch_data  input  128  channel i value on bits [32i+31:32i], sampled when ch_req[i]=1.
REQ-007 ch_done  output  4  1-cycle pulse on channel i when its transfer is acknowledged.
REQ-008 ch_pending  output  4  level, channel i has an unserved request.
REQ-009 xfer_req  output  1  level request to the slow-domain handshake.
REQ-010 xfer_data  output  32  value being transferred; stable while xfer_req=1.
REQ-011 xfer_ack_async  input  1  ack pulse from the slow domain (one slow cycle wide), asynchronous to clk_fast.
REQ-012 timeout_err  output  1  1-cycle pulse when a transfer times out.
REQ-013 err_ch  output  2  channel index of the last timed-out transfer; holds until the next timeout.

Function
REQ-014 SHALL hold a 32-bit buffer and a pending bit per channel; ch_req[i] at cycle N SHALL set pending[i] and load buffer[i] at N+1.
REQ-015 ch_req[i] while pending[i]=1 SHALL overwrite buffer[i] (coalesce): one transfer, latest value.
REQ-016 SHALL synchronize xfer_ack_async through two flip-flops plus one edge-detect flop; ack_rise = sync2 & ~sync3.
REQ-017 FSM states: IDLE, REQ, GAP.
REQ-018 IDLE: if any pending bit is set, SHALL grant by round-robin starting from the channel after the last granted one (index 0 after reset).
REQ-019 On grant: xfer_data <= buffer[g], pending[g] cleared, xfer_req <= 1, state -> REQ, all in the same edge; pending at cycle N+1 gives xfer_req=1 at N+2.
REQ-020 ch_req[g] arriving in the grant cycle or during REQ/GAP SHALL set pending[g] again and SHALL NOT alter xfer_data.
REQ-021 REQ: ack_rise at cycle M SHALL give xfer_req=0 and ch_done[g]=1 at M+1, state -> GAP.
REQ-022 REQ: TIMEOUT_CYCLES cycles with xfer_req=1 and no ack_rise SHALL drop xfer_req, pulse timeout_err, load err_ch=g, give no ch_done, state -> GAP.
REQ-023 ack_rise and timeout in the same cycle: the ack wins.
REQ-024 GAP: SHALL stay exactly GAP_CYCLES cycles with xfer_req=0, then -> IDLE; ack_rise during GAP or IDLE SHALL be ignored.
REQ-025 Timeout and gap counters SHALL be wide enough for their parameters and SHALL clear on every state entry.
REQ-026 ch_pending SHALL equal the pending bits as registered.

Reset
REQ-027 reset_n=0 SHALL asynchronously clear: state=IDLE, pending, buffers, xfer_req=0, xfer_data=0, ch_done=0, timeout_err=0, err_ch=0, sync flops, counters, round-robin pointer (next grant = channel 0).
REQ-028 Reset mid-transfer SHALL abort it without a ch_done or timeout_err pulse; operation resumes on the first edge after release.

Verification
REQ-029 Single request: ch_req=4'b0001, ch_data[31:0]=32'hDEADBEEF at cycle 0 -> xfer_req=1, xfer_data=32'hDEADBEEF at cycle 2; slow ack -> ch_done=4'b0001 3 cycles after ack rise; xfer_req low >=64 cycles.
REQ-030 Round-robin: ch_req=4'b1111 in one cycle with values 1,2,3,4 -> transfers in order 1,2,3,4; a second burst then starts at channel 0.
REQ-031 Coalesce: ch_req[2] with 32'hA then 32'hB while ch2 waits behind ch0 -> exactly one ch2 transfer, xfer_data=32'hB.
REQ-032 Timeout: ch_req[3], ack never returned -> xfer_req high exactly 1024 cycles; timeout_err pulse; err_ch=3; no ch_done[3].
REQ-033 Reset mid-REQ: reset_n low for 3 cycles while xfer_req=1 -> all outputs 0, ch_pending=0, no pulses; a later request is served normally.
REQ-034 Late ack: ack rise during GAP -> ignored; no ch_done and no state change.
